// File: rtl/imm_encoder_pkg.sv
// Shared CPU definitions: instruction format codes, the NOP word, immediate
// range limits and the request payload used by the immediate encoder.
package imm_encoder_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned FMT_W     = 3;
  localparam int unsigned OPCODE_W  = 7;
  localparam int unsigned REG_W     = 5;
  localparam int unsigned FUNCT3_W  = 3;
  localparam int unsigned FUNCT7_W  = 7;

  typedef enum logic [FMT_W-1:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  localparam int signed IMM12_MIN = -2048;
  localparam int signed IMM12_MAX = 2047;
  localparam int signed BOFF_MIN  = -4096;
  localparam int signed BOFF_MAX  = 4094;
  localparam int signed JOFF_MIN  = -1048576;
  localparam int signed JOFF_MAX  = 1048574;

  // fmt is kept as raw bits so the illegal codes 6 and 7 can be carried.
  typedef struct packed {
    logic [FMT_W-1:0]    fmt;
    logic [OPCODE_W-1:0] opcode;
    logic [REG_W-1:0]    rd;
    logic [REG_W-1:0]    rs1;
    logic [REG_W-1:0]    rs2;
    logic [FUNCT3_W-1:0] funct3;
    logic [FUNCT7_W-1:0] funct7;
    logic [XLEN-1:0]     imm;
  } imm_req_t;

endpackage

// File: rtl/imm_encoder_pack.sv
// Combinational RV32I field packer and immediate legality check; an illegal
// word is replaced by the NOP encoding.
module imm_pack
  import imm_encoder_pkg::*;
(
  input  imm_req_t        req,
  output logic [XLEN-1:0] inst_c,
  output logic            err_c
);

  logic signed [XLEN-1:0] simm;
  logic [XLEN-1:0]        raw;

  assign simm = $signed(req.imm);

  always_comb begin
    raw   = '0;
    err_c = 1'b0;
    case (req.fmt)
      FMT_R: begin
        raw = {req.funct7, req.rs2, req.rs1, req.funct3, req.rd, req.opcode};
      end
      FMT_I: begin
        raw   = {req.imm[11:0], req.rs1, req.funct3, req.rd, req.opcode};
        err_c = (simm < IMM12_MIN) || (simm > IMM12_MAX);
      end
      FMT_S: begin
        raw   = {req.imm[11:5], req.rs2, req.rs1, req.funct3, req.imm[4:0], req.opcode};
        err_c = (simm < IMM12_MIN) || (simm > IMM12_MAX);
      end
      FMT_B: begin
        raw   = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, req.funct3,
                 req.imm[4:1], req.imm[11], req.opcode};
        err_c = (simm < BOFF_MIN) || (simm > BOFF_MAX) || req.imm[0];
      end
      FMT_U: begin
        raw   = {req.imm[31:12], req.rd, req.opcode};
        err_c = (req.imm[11:0] != 12'd0);
      end
      FMT_J: begin
        raw   = {req.imm[20], req.imm[10:1], req.imm[11], req.imm[19:12], req.rd, req.opcode};
        err_c = (simm < JOFF_MIN) || (simm > JOFF_MAX) || req.imm[0];
      end
      default: begin
        err_c = 1'b1;
      end
    endcase
  end

  assign inst_c = err_c ? NOP_INST : raw;

endmodule

// File: rtl/imm_encoder.sv
// Two-stage immediate encoder: S1 holds the request, S2 holds the packed word;
// valid/ready handshakes on both sides and a saturating error counter.
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           fmt,
  input  logic [6:0]           opcode,
  input  logic [4:0]           rd,
  input  logic [4:0]           rs1,
  input  logic [4:0]           rs2,
  input  logic [2:0]           funct3,
  input  logic [6:0]           funct7,
  input  logic [31:0]          imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          inst,
  output logic                 range_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  logic        s1_valid;
  logic        s2_valid;
  imm_req_t    s1_req;
  logic        s1_adv_c;
  logic [31:0] pack_inst_c;
  logic        pack_err_c;

  assign s1_adv_c  = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s1_adv_c;
  assign out_valid = s2_valid;

  imm_pack u_pack (
    .req    (s1_req),
    .inst_c (pack_inst_c),
    .err_c  (pack_err_c)
  );

  // S1: capture the request whenever the stage is free or emptying.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_req   <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_req <= '{fmt: fmt, opcode: opcode, rd: rd, rs1: rs1, rs2: rs2,
                    funct3: funct3, funct7: funct7, imm: imm};
      end
    end
  end

  // S2: packed word; held stable while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      inst      <= '0;
      range_err <= 1'b0;
    end else if (s1_adv_c) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        inst      <= pack_inst_c;
        range_err <= pack_err_c;
      end
    end
  end

  // Count delivered erroneous words, sticking at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (s2_valid && out_ready && range_err && (err_cnt != {ERR_CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end

endmodule
